parking_day_log: RTL and testbench
==================================

// Module: parking_day_log
// PURPOSE
//   Per-hour logger and end-of-day reader for the parking-lot simulation; consumes the
//   hours/endDay outputs of the hour-tracking FSM together with enter/exit car pulses.
//   During the day it tracks lot occupancy and records the number of cars entering in
//   each of the 8 hours. When endDay asserts it freezes the log and plays the 8 hourly
//   entries back sequentially for the display path.
// PARAMETERS
//   CAPACITY  3  maximum cars in lot; enters at full occupancy are rejected
//   CNT_W     4  width of each hourly entry counter (saturating)
//   DWELL     2  clock cycles each hourly entry is presented during playback (>=1)
// PORTS
//   clk         in   1        system clock, all logic on posedge
//   reset       in   1        synchronous, active-high
//   enter       in   1        one-cycle pulse: car arrives at entrance
//   exit        in   1        one-cycle pulse: car leaves lot
//   hours       in   3        current hour index 0..7 from hour FSM
//   endDay      in   1        high while hour FSM is in end-of-day display state
//   occupancy   out  $clog2(CAPACITY+1)  cars currently in lot
//   full        out  1        occupancy == CAPACITY
//   day_total   out  CNT_W+3  cars accepted today (saturating)
//   pb_valid    out  1        playback data valid
//   pb_hour     out  3        hour index being played back
//   pb_count    out  CNT_W    cars entered during pb_hour
// BEHAVIOUR
//   - Reset: state RECORD; log[0..7]=0; occupancy=0; full=0; day_total=0; pb_valid=0;
//     pb_hour=0; pb_count=0; dwell counter=0. All outputs registered.
//   - States: RECORD, PLAYBACK.
//   - RECORD: accepted enter = enter & ~full. On accepted enter: occupancy+1,
//     log[hours]+1 (saturate at 2^CNT_W-1), day_total+1 (saturate). Visible next cycle.
//   - exit with occupancy==0 ignored. Otherwise exit: occupancy-1.
//   - enter & exit same cycle: exit processed first against current value, then enter
//     checked against post-exit value -> at full, both accepted, occupancy unchanged,
//     log and day_total increment; at 0, exit ignored, enter accepted.
//   - RECORD -> PLAYBACK on first cycle endDay=1 (sampled); log frozen from that edge.
//     Next cycle: pb_valid=1, pb_hour=0, pb_count=log[0].
//   - PLAYBACK: each entry held DWELL cycles, then pb_hour increments; after 7 wraps to 0
//     and repeats while endDay stays high. pb_count always equals log[pb_hour].
//   - In PLAYBACK, enter/exit still update occupancy/full; log and day_total frozen.
//   - PLAYBACK -> RECORD on first cycle endDay=0: next cycle pb_valid=0, pb_hour=0,
//     pb_count=0, log[0..7]=0, day_total=0 (new day); occupancy preserved.
//   - hours input ignored in PLAYBACK; in RECORD it is used directly as log index.
//   - reset asserted in any state (mid-playback included) overrides all other inputs.
// TESTING  (CAPACITY=3, CNT_W=4, DWELL=2)
//   1. Reset, then hours=0, 2 enter pulses -> occupancy=2, log[0]=2, day_total=2, full=0.
//   2. hours=1, 3 enters from occupancy 2 -> first accepted (occupancy=3, full=1),
//      next two rejected; log[1]=1, day_total=3.
//   3. At full, enter&exit same cycle -> occupancy stays 3, log[hours]+1; at occupancy 0,
//      lone exit -> occupancy stays 0.
//   4. Log {2,1,0,0,0,0,0,4}, raise endDay -> pb_valid=1 next cycle; pb_hour 0,0,1,1,2,2..
//      7,7,0 with pb_count 2,2,1,1,0,..,4,4,2; enter during playback changes occupancy only.
//   5. Drop endDay -> pb_valid=0 next cycle, all log entries and day_total read 0 in
//      following playback; occupancy unchanged.
//   6. 16 enters in one hour (exits interleaved) -> log entry saturates at 15; reset
//      mid-playback -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/parking_day_log.sv
// Parking-lot day logger: tracks occupancy, counts accepted entries per hour, and on end of day
// freezes the hourly log and cycles through it for the display path.
module parking_day_log #(
  parameter int unsigned Capacity = 3,
  parameter int unsigned CntW     = 4,
  parameter int unsigned Dwell    = 2,
  localparam int unsigned OccW    = $clog2(Capacity + 1),
  localparam int unsigned TotW    = CntW + 3
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            enter_i,
  input  logic            exit_i,
  input  logic [2:0]      hours_i,
  input  logic            end_day_i,
  output logic [OccW-1:0] occupancy_o,
  output logic            full_o,
  output logic [TotW-1:0] day_total_o,
  output logic            pb_valid_o,
  output logic [2:0]      pb_hour_o,
  output logic [CntW-1:0] pb_count_o
);

  localparam int unsigned DwW = (Dwell > 1) ? $clog2(Dwell) : 1;

  typedef enum logic [0:0] {StRecord, StPlayback} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   log_q [8];
  logic [CntW-1:0]   log_d [8];
  logic [OccW-1:0]   occ_q, occ_d, occ_post;
  logic              full_q, full_d;
  logic [TotW-1:0]   total_q, total_d;
  logic              pb_valid_q, pb_valid_d;
  logic [2:0]        pb_hour_q, pb_hour_d;
  logic [CntW-1:0]   pb_count_q, pb_count_d;
  logic [DwW-1:0]    dwell_q, dwell_d;
  logic              exit_ok, enter_ok;

  always_comb begin
    state_d    = state_q;
    log_d      = log_q;
    total_d    = total_q;
    pb_valid_d = pb_valid_q;
    pb_hour_d  = pb_hour_q;
    pb_count_d = pb_count_q;
    dwell_d    = dwell_q;

    // Exit is resolved first so an enter at full can take the freed space.
    exit_ok  = exit_i && (occ_q != '0);
    occ_post = occ_q - OccW'(exit_ok);
    enter_ok = enter_i && (occ_post != OccW'(Capacity));
    occ_d    = occ_post + OccW'(enter_ok);
    full_d   = (occ_d == OccW'(Capacity));

    unique case (state_q)
      StRecord: begin
        if (end_day_i) begin
          state_d    = StPlayback;
          pb_valid_d = 1'b1;
          pb_hour_d  = 3'd0;
          pb_count_d = log_q[0];
          dwell_d    = '0;
        end else if (enter_ok) begin
          if (log_q[hours_i] != '1) log_d[hours_i] = log_q[hours_i] + 1'b1;
          if (total_q != '1) total_d = total_q + 1'b1;
        end
      end
      StPlayback: begin
        if (!end_day_i) begin
          state_d    = StRecord;
          pb_valid_d = 1'b0;
          pb_hour_d  = 3'd0;
          pb_count_d = '0;
          dwell_d    = '0;
          total_d    = '0;
          for (int i = 0; i < 8; i++) log_d[i] = '0;
        end else begin
          if (dwell_q == DwW'(Dwell - 1)) begin
            dwell_d   = '0;
            pb_hour_d = pb_hour_q + 3'd1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
          pb_count_d = log_q[pb_hour_d];
        end
      end
      default: state_d = StRecord;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StRecord;
      for (int i = 0; i < 8; i++) log_q[i] <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      total_q    <= '0;
      pb_valid_q <= 1'b0;
      pb_hour_q  <= 3'd0;
      pb_count_q <= '0;
      dwell_q    <= '0;
    end else begin
      state_q    <= state_d;
      log_q      <= log_d;
      occ_q      <= occ_d;
      full_q     <= full_d;
      total_q    <= total_d;
      pb_valid_q <= pb_valid_d;
      pb_hour_q  <= pb_hour_d;
      pb_count_q <= pb_count_d;
      dwell_q    <= dwell_d;
    end
  end

  assign occupancy_o = occ_q;
  assign full_o      = full_q;
  assign day_total_o = total_q;
  assign pb_valid_o  = pb_valid_q;
  assign pb_hour_o   = pb_hour_q;
  assign pb_count_o  = pb_count_q;

endmodule

// File: tb/tb_parking_day_log.sv
// Directed bench for parking_day_log (Capacity=3, CntW=4, Dwell=2) with hand-computed values.
module tb_parking_day_log;

  logic       clk = 1'b0;
  logic       reset, enter, exit_p, end_day;
  logic [2:0] hours;
  logic [1:0] occupancy;
  logic       full;
  logic [6:0] day_total;
  logic       pb_valid;
  logic [2:0] pb_hour;
  logic [3:0] pb_count;

  int n_total = 0;
  int n_bad   = 0;
  int exp_log [8];

  parking_day_log #(
    .Capacity(3),
    .CntW    (4),
    .Dwell   (2)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .enter_i    (enter),
    .exit_i     (exit_p),
    .hours_i    (hours),
    .end_day_i  (end_day),
    .occupancy_o(occupancy),
    .full_o     (full),
    .day_total_o(day_total),
    .pb_valid_o (pb_valid),
    .pb_hour_o  (pb_hour),
    .pb_count_o (pb_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic en, input logic ex);
    enter  = en;
    exit_p = ex;
    tick();
    enter  = 1'b0;
    exit_p = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, " occ"},   int'(occupancy), 0);
    check_val({tag, " full"},  int'(full),      0);
    check_val({tag, " total"}, int'(day_total), 0);
    check_val({tag, " valid"}, int'(pb_valid),  0);
    check_val({tag, " hour"},  int'(pb_hour),   0);
    check_val({tag, " count"}, int'(pb_count),  0);
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; exit_p = 1'b0; end_day = 1'b0; hours = 3'd0;
    tick(); tick();
    reset = 1'b0;
    check_reset_state("reset");

    // 1: two enters in hour 0
    hours = 3'd0;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check_val("t1 occ", int'(occupancy), 2);
    check_val("t1 total", int'(day_total), 2);
    check_val("t1 full", int'(full), 0);

    // 2: three enters in hour 1, only the first fits
    hours = 3'd1;
    pulse(1'b1, 1'b0);
    check_val("t2 occ first", int'(occupancy), 3);
    check_val("t2 full first", int'(full), 1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check_val("t2 occ", int'(occupancy), 3);
    check_val("t2 total", int'(day_total), 3);

    // 3: simultaneous enter/exit at full, then drain, lone exit at 0, enter/exit at 0
    hours = 3'd7;
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
    check_val("t3 occ full swap", int'(occupancy), 3);
    check_val("t3 total swap", int'(day_total), 6);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
    check_val("t3 occ drained", int'(occupancy), 0);
    check_val("t3 full drained", int'(full), 0);
    pulse(1'b0, 1'b1);
    check_val("t3 occ lone exit", int'(occupancy), 0);
    pulse(1'b1, 1'b1);
    check_val("t3 occ zero swap", int'(occupancy), 1);
    check_val("t3 total zero swap", int'(day_total), 7);

    // 4: playback of {2,1,0,0,0,0,0,4}; enter on the switching edge is not logged
    exp_log = '{2, 1, 0, 0, 0, 0, 0, 4};
    hours   = 3'd0;
    end_day = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k == 0) pulse(1'b1, 1'b0);
      else if (k == 5) begin
        hours = 3'd3;
        pulse(1'b1, 1'b0);
      end else tick();
      check_val($sformatf("t4 valid k%0d", k), int'(pb_valid), 1);
      check_val($sformatf("t4 hour k%0d", k), int'(pb_hour), (k / 2) % 8);
      check_val($sformatf("t4 count k%0d", k), int'(pb_count), exp_log[(k / 2) % 8]);
      if (k == 0) check_val("t4 occ on switch", int'(occupancy), 2);
    end
    check_val("t4 occ", int'(occupancy), 3);
    check_val("t4 full", int'(full), 1);
    check_val("t4 total frozen", int'(day_total), 7);

    // 5: new day clears log and total, keeps occupancy
    end_day = 1'b0;
    tick();
    check_val("t5 valid", int'(pb_valid), 0);
    check_val("t5 hour", int'(pb_hour), 0);
    check_val("t5 count", int'(pb_count), 0);
    check_val("t5 total", int'(day_total), 0);
    check_val("t5 occ", int'(occupancy), 3);
    end_day = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_val($sformatf("t5 cleared k%0d", k), int'(pb_count), 0);
    end
    end_day = 1'b0;
    tick();

    // 6: saturation of an hourly entry and of the day total, then reset mid-playback
    hours = 3'd2;
    for (int i = 0; i < 16; i++) begin
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
    end
    check_val("t6 total 16", int'(day_total), 16);
    for (int i = 0; i < 120; i++) pulse(1'b1, 1'b1);
    check_val("t6 total sat", int'(day_total), 127);
    check_val("t6 occ", int'(occupancy), 3);
    end_day = 1'b1;
    for (int k = 0; k <= 4; k++) tick();
    check_val("t6 hour", int'(pb_hour), 2);
    check_val("t6 count sat", int'(pb_count), 15);
    reset = 1'b1;
    tick();
    check_reset_state("t6 reset");
    reset   = 1'b0;
    end_day = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
